// File: rtl/stream_block_capture_pkg.sv
// stream_block_capture_pkg: shared state type, LFSR constants and default sizes
package stream_block_capture_pkg;
    localparam int DEF_WIDTH          = 32;
    localparam int DEF_MAX_BLOCK_SIZE = 32;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois right-shift mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef enum logic {IDLE, RECV} state_t;
endpackage

// File: rtl/stream_rate_lfsr.sv
// stream_rate_lfsr: 16-bit Galois LFSR with enable and seed load on reset
module stream_rate_lfsr
    import stream_block_capture_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [7:0]  rnd
);
    logic [15:0] state;
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= seed;
        else if (en)
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
    assign rnd = state[7:0];
endmodule

// File: rtl/stream_block_capture.sv
// stream_block_capture: stream sink storing one block of words for random readback
// Optional STREAM_BLOCK_CAPTURE_THROTTLE_EN adds rate_i and an LFSR-driven ready throttle.
module stream_block_capture
    import stream_block_capture_pkg::*;
#(
    parameter  int WIDTH          = DEF_WIDTH,
    parameter  int MAX_BLOCK_SIZE = DEF_MAX_BLOCK_SIZE,
    localparam int LW             = $clog2(MAX_BLOCK_SIZE + 1),
    localparam int AW             = $clog2(MAX_BLOCK_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] stream_s_data_i,
    input  logic             stream_s_valid_i,
    output logic             stream_s_ready_o,
    input  logic             start_i,
    input  logic [LW-1:0]    len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LW-1:0]    count_o,
`ifdef STREAM_BLOCK_CAPTURE_THROTTLE_EN
    input  logic [7:0]       rate_i,
`endif
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);
    state_t           state;
    logic [LW-1:0]    len;
    logic [LW-1:0]    len_clamp;
    logic [WIDTH-1:0] mem [MAX_BLOCK_SIZE];
    logic             rate_ok;
    logic             xfer;
    logic             last;
    logic             in_range;

`ifdef STREAM_BLOCK_CAPTURE_THROTTLE_EN
    logic [7:0] rnd;
    stream_rate_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .seed  (LFSR_SEED),
        .rnd   (rnd)
    );
    assign rate_ok = (rnd < rate_i) || (rate_i == 8'hFF);
`else
    assign rate_ok = 1'b1;
`endif

    assign stream_s_ready_o = (state == RECV) && rate_ok;
    assign busy_o           = state == RECV;
    assign xfer             = stream_s_valid_i && stream_s_ready_o;
    assign last             = xfer && (count_o + LW'(1) == len);
    assign len_clamp        = (len_i > LW'(MAX_BLOCK_SIZE)) ? LW'(MAX_BLOCK_SIZE) : len_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            len     <= '0;
            count_o <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                if (start_i) begin
                    len     <= len_clamp;
                    count_o <= '0;
                    done_o  <= len_clamp == '0;
                    state   <= (len_clamp == '0) ? IDLE : RECV;
                end
            end else if (xfer) begin
                count_o <= count_o + LW'(1);
                if (last) begin
                    state  <= IDLE;
                    done_o <= 1'b1;
                end
            end
        end
    end

    // Buffer kept free of reset so it maps onto a simple dual-port RAM
    always_ff @(posedge clk) begin
        if (xfer && rst_n)
            mem[count_o[AW-1:0]] <= stream_s_data_i;
    end

    if (2 ** AW == MAX_BLOCK_SIZE) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_part
        assign in_range = 32'(rd_addr_i) < MAX_BLOCK_SIZE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_data_o <= '0;
        else
            rd_data_o <= in_range ? mem[rd_addr_i] : '0;
    end
endmodule

// File: tb/tb_stream_block_capture.sv
// tb_stream_block_capture: directed scoreboard bench for stream_block_capture
module tb_stream_block_capture;
    localparam int W  = 32;
    localparam int M  = 32;
    localparam int LW = 6;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [LW-1:0] count;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
`ifdef STREAM_BLOCK_CAPTURE_THROTTLE_EN
    logic [7:0]    rate = 8'hFF;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mbuf [M];
    logic [W-1:0] exp_q [$];

    stream_block_capture dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream_s_data_i  (s_data),
        .stream_s_valid_i (s_valid),
        .stream_s_ready_o (s_ready),
        .start_i          (start),
        .len_i            (len),
        .busy_o           (busy),
        .done_o           (done),
        .count_o          (count),
`ifdef STREAM_BLOCK_CAPTURE_THROTTLE_EN
        .rate_i           (rate),
`endif
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit det();
`ifdef STREAM_BLOCK_CAPTURE_THROTTLE_EN
        return rate == 8'hFF;
`else
        return 1'b1;
`endif
    endfunction

    task automatic start_blk(input int l);
        start = 1'b1;
        len   = LW'(l);
        cyc();
        start = 1'b0;
        chk("busy_start", 32'(busy), (l == 0) ? 0 : 1);
        chk("count_start", 32'(count), 0);
        if (l == 0) begin
            chk("done_len0", 32'(done), 1);
            cyc();
            chk("done_len0_off", 32'(done), 0);
        end
    endtask

    task automatic send(input int n, input logic [W-1:0] base, input bit gappy, input bit fin,
                        output int rdy_cyc, output int cycs);
        int k = 0;
        rdy_cyc = 0;
        cycs    = 0;
        while (k < n && cycs < 3000) begin
            s_data  = base * W'(k + 1);
            s_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (det()) chk("ready", 32'(s_ready), 1);
            rdy_cyc += int'(s_ready);
            cycs++;
            if (s_valid && s_ready) begin
                mbuf[k] = s_data;
                k++;
            end
            cyc();
            chk("done_timing", 32'(done), (fin && k == n) ? 1 : 0);
        end
        s_valid = 1'b0;
        chk("beats", 32'(k), 32'(n));
    endtask

    task automatic after_done(input int l);
        cyc();
        chk("done_off", 32'(done), 0);
        chk("busy_off", 32'(busy), 0);
        chk("ready_off", 32'(s_ready), 0);
        chk("count_final", 32'(count), 32'(l));
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        repeat (3) begin
            cyc();
            chk("ready_after", 32'(s_ready), 0);
            chk("count_hold", 32'(count), 32'(l));
        end
        s_valid = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_addr = AW'(a);
        exp_q.push_back(mbuf[a]);
        cyc();
        chk("rd_data", rd_data, exp_q.pop_front());
    endtask

    initial begin
        int rc, cc, hi;
        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; start = 1'b0; len = '0; rd_addr = '0;
        repeat (5) cyc();
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        cyc();

        start_blk(4);
        send(4, 32'h11111111, 1'b0, 1'b1, rc, cc);
        chk("basic_cycles", 32'(cc), 4);
        after_done(4);
        for (int a = 0; a < 4; a++) rd(a);

        start_blk(8);
        start = 1'b1; len = LW'(1);
        cyc();
        start = 1'b0;
        chk("start_in_recv_busy", 32'(busy), 1);
        chk("start_in_recv_count", 32'(count), 0);
        send(8, 32'hA5A50003, 1'b1, 1'b1, rc, cc);
        after_done(8);
        for (int a = 0; a < 8; a++) rd(a);

        start_blk(0);
        chk("len0_ready", 32'(s_ready), 0);

        start_blk(40);
        send(32, 32'h01020305, 1'b0, 1'b1, rc, cc);
        after_done(32);
        rd(31);
        rd(0);
        rd(16);

        start_blk(8);
        send(3, 32'h0BAD0001, 1'b0, 1'b0, rc, cc);
        rst_n = 1'b0;
        cyc();
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(s_ready), 0);
        rst_n = 1'b1;
        cyc();
        chk("abort_done_after", 32'(done), 0);
        chk("abort_busy_after", 32'(busy), 0);
        start_blk(2);
        send(2, 32'h600DF00D, 1'b0, 1'b1, rc, cc);
        after_done(2);
        rd(0);
        rd(1);
        rd(2);

`ifdef STREAM_BLOCK_CAPTURE_THROTTLE_EN
        rate = 8'h00;
        start_blk(4);
        s_valid = 1'b1;
        s_data  = 32'hCAFEF00D;
        hi = 0;
        repeat (64) begin
            hi += int'(s_ready);
            cyc();
        end
        s_valid = 1'b0;
        chk("rate0_ready", 32'(hi), 0);
        chk("rate0_count", 32'(count), 0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        rate = 8'h20;
        start_blk(32);
        send(32, 32'h13579BDF, 1'b0, 1'b1, rc, cc);
        chk("duty", 32'(rc * 16 >= cc && rc * 4 <= cc), 1);
        rate = 8'hFF;
        after_done(32);
        for (int a = 0; a < 32; a++) rd(a);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
